// File: rtl/matrix_pkg.sv
// matrix_pkg: shared defaults, state type and address-width helper for the 3x3 window generator
package matrix_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ROW_WIDTH_DEF = 12;
  localparam int WIN = 3;
  typedef enum logic {IDLE, ACTIVE} state_t;
  function automatic int CLOG2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/ip_ram.sv
// ip_ram: simple dual-port RAM, write on port a, registered read on port b with RAM_DELAY stages
module ip_ram
  import matrix_pkg::*;
#(
  parameter int RAM_DEEP = 16,
  parameter int RAM_DATA_BITWIDTH = 8,
  parameter int RAM_DELAY = 1,
  localparam int AW = CLOG2(RAM_DEEP)
) (
  input  logic                         clka,
  input  logic                         wea,
  input  logic [AW-1:0]                addra,
  input  logic [RAM_DATA_BITWIDTH-1:0] dina,
  input  logic                         clkb,
  input  logic                         enb,
  input  logic [AW-1:0]                addrb,
  output logic [RAM_DATA_BITWIDTH-1:0] doutb
);
  logic [RAM_DATA_BITWIDTH-1:0] r_mem [RAM_DEEP];
  logic [RAM_DATA_BITWIDTH-1:0] r_pipe [RAM_DELAY];
  // write port; contents deliberately never cleared
  always_ff @(posedge clka)
    if (wea) r_mem[addra] <= dina;
  // read port returns old data on same-address collision
  always_ff @(posedge clkb)
    if (enb) begin
      r_pipe[0] <= r_mem[addrb];
      for (int i = 1; i < RAM_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  assign doutb = r_pipe[RAM_DELAY-1];
endmodule

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: raster-stream 3x3 sliding-window generator built on two line buffers
module matrix_3x3_gen
  import matrix_pkg::*;
#(
  parameter int IMG_WIDTH = 300,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ROW_WIDTH = ROW_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_sof,
  input  logic                             in_de,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             out_de,
  output logic                             out_sof,
  output logic [WIN*WIN*DATA_WIDTH-1:0]    out_win
);
  localparam int AW = CLOG2(IMG_WIDTH);
  localparam int DW = DATA_WIDTH;
  state_t r_state;
  logic [AW-1:0] r_col, r_col1;
  logic [ROW_WIDTH-1:0] r_row;
  logic r_v1, r_ok1, r_sof1;
  logic [DW-1:0] r_pix1;
  logic [WIN*WIN*DW-1:0] r_win;
  logic w_acc, w_eol;
  logic [AW-1:0] w_c;
  logic [ROW_WIDTH-1:0] w_r;
  logic [DW-1:0] w_lb0, w_lb1;
  logic [WIN*WIN*DW-1:0] w_next;
  assign w_acc = in_de & (in_sof | (r_state == ACTIVE));
  assign w_c = in_sof ? '0 : r_col;
  assign w_r = in_sof ? '0 : r_row;
  assign w_eol = w_c == AW'(IMG_WIDTH - 1);
  assign w_next = {r_pix1, r_win[7*DW +: 2*DW], w_lb0, r_win[4*DW +: 2*DW], w_lb1, r_win[DW +: 2*DW]};
  ip_ram #(.RAM_DEEP(IMG_WIDTH), .RAM_DATA_BITWIDTH(DW), .RAM_DELAY(1)) u_lb0 (
    .clka(clk), .wea(r_v1), .addra(r_col1), .dina(r_pix1),
    .clkb(clk), .enb(w_acc), .addrb(w_c), .doutb(w_lb0)
  );
  ip_ram #(.RAM_DEEP(IMG_WIDTH), .RAM_DATA_BITWIDTH(DW), .RAM_DELAY(1)) u_lb1 (
    .clka(clk), .wea(r_v1), .addra(r_col1), .dina(w_lb0),
    .clkb(clk), .enb(w_acc), .addrb(w_c), .doutb(w_lb1)
  );
  // frame state, raster position, one-cycle pixel delay and window/output registers
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_col <= '0;
      r_row <= '0;
      r_v1 <= 1'b0;
      r_ok1 <= 1'b0;
      r_sof1 <= 1'b0;
      r_col1 <= '0;
      r_pix1 <= '0;
      r_win <= '0;
      out_de <= 1'b0;
      out_sof <= 1'b0;
      out_win <= '0;
    end else begin
      if (in_de & in_sof) r_state <= ACTIVE;
      if (w_acc) begin
        r_col <= w_eol ? '0 : w_c + AW'(1);
        r_row <= (w_eol && ~&w_r) ? w_r + ROW_WIDTH'(1) : w_r;
      end
      r_v1 <= w_acc;
      r_pix1 <= in_data;
      r_col1 <= w_c;
      r_ok1 <= (w_r >= ROW_WIDTH'(2)) && (w_c >= AW'(2));
      r_sof1 <= (w_r == ROW_WIDTH'(2)) && (w_c == AW'(2));
      out_de <= r_v1 & r_ok1;
      out_sof <= r_v1 & r_ok1 & r_sof1;
      if (r_v1) r_win <= w_next;
      if (r_v1 & r_ok1) out_win <= w_next;
    end
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: directed table-driven bench for the 3x3 window generator (4-pixel lines)
module tb_matrix_3x3_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_sof = 1'b0;
  logic in_de = 1'b0;
  logic [7:0] in_data = '0;
  logic out_de, out_sof;
  logic [71:0] out_win;
  typedef struct {int r; int c; logic [71:0] win; logic sof;} vec_t;
  typedef struct {int cyc; logic [71:0] win; logic sof;} ev_t;
  vec_t tab[4];
  ev_t got_q[$];
  int exp_q[$];
  int cyc = 0, pass_n = 0, total_n = 0, stab_err = 0;
  logic [71:0] prev_win = '0;
  logic last_rst = 1'b1;

  matrix_3x3_gen #(.IMG_WIDTH(4), .DATA_WIDTH(8), .ROW_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_sof(in_sof), .in_de(in_de), .in_data(in_data),
    .out_de(out_de), .out_sof(out_sof), .out_win(out_win)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_de === 1'b1) got_q.push_back('{cyc, out_win, out_sof});
    else if (!last_rst && out_win !== prev_win) stab_err++;
    prev_win = out_win;
    last_rst = rst;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic px(input logic sof, input logic [7:0] d, input logic ok);
    @(posedge clk); #1;
    in_de = 1'b1; in_sof = sof; in_data = d;
    if (ok) exp_q.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_de = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] base, input logic gaps, input int npx);
    int r, c;
    for (int p = 0; p < npx; p++) begin
      r = p / 4;
      c = p % 4;
      px(p == 0, base + 8'(16 * r + c), r >= 2 && c >= 2);
      if (gaps) idle($urandom_range(1, 3));
    end
  endtask

  task automatic verify(input logic [7:0] off, input string nm);
    logic [71:0] w;
    idle(6);
    chk({nm, " count"}, 72'(got_q.size()), 72'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      w = tab[i].win;
      for (int b = 0; b < 9; b++) w[b*8 +: 8] = w[b*8 +: 8] + off;
      chk($sformatf("%s win(%0d,%0d)", nm, tab[i].r, tab[i].c), got_q[i].win, w);
      chk($sformatf("%s sof(%0d,%0d)", nm, tab[i].r, tab[i].c), 72'(got_q[i].sof), 72'(tab[i].sof));
      if (i < exp_q.size())
        chk($sformatf("%s cyc(%0d,%0d)", nm, tab[i].r, tab[i].c), 72'(got_q[i].cyc), 72'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tab[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00, 1'b1};
    tab[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01, 1'b0};
    tab[2] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10, 1'b0};
    tab[3] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11, 1'b0};
    in_de = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_data = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("rst de %0d", i), 72'(out_de), 72'd0);
      chk($sformatf("rst sof %0d", i), 72'(out_sof), 72'd0);
      chk($sformatf("rst win %0d", i), out_win, 72'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) px(1'b0, 8'(i), 1'b0);
    idle(6);
    chk("no sof count", 72'(got_q.size()), 72'd0);
    got_q.delete();
    frame(8'h00, 1'b0, 16);
    verify(8'h00, "cont");
    frame(8'h00, 1'b1, 16);
    verify(8'h00, "gaps");
    frame(8'h00, 1'b0, 9);
    frame(8'h80, 1'b0, 16);
    verify(8'h80, "resof");
    frame(8'h00, 1'b0, 12);
    @(posedge clk); #1;
    rst = 1'b1; in_de = 1'b1; in_sof = 1'b0; in_data = 8'h30;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) px(1'b0, 8'h31 + 8'(i), 1'b0);
    idle(6);
    chk("rst drop count", 72'(got_q.size()), 72'd1);
    got_q.delete();
    exp_q.delete();
    frame(8'h00, 1'b0, 16);
    verify(8'h00, "after rst");
    chk("win stable", 72'(stab_err), 72'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
